// File: rtl/frame_pkg.sv
// ============================================================================
// Module   : frame_pkg
// Brief    : Frame-memory word layout shared by frame_writer and edge_detector.
// Revision : 1.0
// ============================================================================
`default_nettype none

package frame_pkg;

    localparam int WORD_W  = 36;
    localparam int ADDR_W  = 19;
    localparam int COL_W   = 10;
    localparam int ROW_W   = 9;
    localparam int PIX_W   = 30;
    localparam int LUMA_HI = 29;
    localparam int LUMA_LO = 20;
    localparam int ENTRY_W = ADDR_W + PIX_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  pix;
    } wr_entry_t;

    // Row stride is fixed at 1024 words regardless of active width.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_skid_fifo.sv
// ============================================================================
// Module   : pixel_skid_fifo
// Brief    : Two-entry FIFO with registered full/empty; head is a register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pixel_skid_fifo #(
    parameter int DATA_W = 49
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_slot0;
    logic [DATA_W-1:0] r_slot1;
    logic              r_full;
    logic              r_empty;
    logic              w_push;
    logic              w_pop;

    assign w_push  = i_push & ~r_full;
    assign w_pop   = i_pop & ~r_empty;
    assign o_head  = r_slot0;
    assign o_full  = r_full;
    assign o_empty = r_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_empty) begin
                        r_slot0 <= i_data;
                        r_empty <= 1'b0;
                    end else begin
                        r_slot1 <= i_data;
                        r_full  <= 1'b1;
                    end
                end
                2'b01: begin
                    if (r_full) begin
                        r_slot0 <= r_slot1;
                        r_full  <= 1'b0;
                    end else begin
                        r_empty <= 1'b1;
                    end
                end
                // Both together only happens with exactly one entry held.
                2'b11: r_slot0 <= i_data;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/frame_writer.sv
// ============================================================================
// Module   : frame_writer
// Brief    : Writes one captured frame into frame memory per start/done pair.
// Revision : 1.0
// ============================================================================
`default_nettype none

module frame_writer
    import frame_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              busy,
    output logic              sync_err,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    output logic              write_en,
    input  logic              write_ready,
    output logic [ADDR_W-1:0] write_addr,
    output logic [WORD_W-1:0] write_data
);

    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_wait_sof = 2'd1;
    localparam logic [1:0] c_write    = 2'd2;
    localparam logic [1:0] c_done     = 2'd3;

    localparam logic [COL_W-1:0] c_last_col = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] c_last_row = ROW_W'(HEIGHT - 1);

    logic [1:0]         r_state;
    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic               r_last_taken;
    logic               r_done;
    logic               r_sync_err;

    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_head_bits;
    wr_entry_t          w_head;
    wr_entry_t          w_push_entry;
    logic               w_taking;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [ROW_W-1:0]   w_cur_row;
    logic [COL_W-1:0]   w_cur_col;
    logic               w_row_end;
    logic               w_is_last;

    assign w_taking  = (r_state == c_wait_sof) | ((r_state == c_write) & ~r_last_taken);
    assign pix_ready = w_taking & ~w_full;
    assign w_accept  = pix_valid & pix_ready;
    assign w_push    = w_accept & ((r_state == c_write) | pix_sof);
    assign w_pop     = ~w_empty & write_ready;

    // Any SOF restarts the frame at (0,0); in WAIT_SOF it is the normal start.
    assign w_cur_row = pix_sof ? '0 : r_row;
    assign w_cur_col = pix_sof ? '0 : r_col;
    assign w_row_end = (w_cur_col == c_last_col);
    assign w_is_last = w_row_end & (w_cur_row == c_last_row);

    assign w_push_entry = '{addr: pix_addr(w_cur_row, w_cur_col), pix: pix_data};

    pixel_skid_fifo #(
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head     = w_head_bits;
    assign write_en   = ~w_empty;
    assign write_addr = w_head.addr;
    assign write_data = {{(WORD_W - PIX_W){1'b0}}, w_head.pix};
    assign done       = r_done;
    assign busy       = (r_state != c_idle);
    assign sync_err   = r_sync_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_idle;
            r_row        <= '0;
            r_col        <= '0;
            r_last_taken <= 1'b0;
            r_done       <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_push) begin
                r_col        <= w_row_end ? '0 : w_cur_col + 1'b1;
                r_row        <= w_row_end ? w_cur_row + 1'b1 : w_cur_row;
                r_last_taken <= w_is_last;
                if (pix_sof && (r_state == c_write) && ((r_row != '0) || (r_col != '0)))
                    r_sync_err <= 1'b1;
            end
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_state      <= c_wait_sof;
                        r_sync_err   <= 1'b0;
                        r_row        <= '0;
                        r_col        <= '0;
                        r_last_taken <= 1'b0;
                    end
                end
                c_wait_sof: begin
                    if (w_push)
                        r_state <= c_write;
                end
                c_write: begin
                    // Final entry leaves the buffer: nothing else can be pending.
                    if (r_last_taken && w_pop && !w_full)
                        r_state <= c_done;
                end
                c_done: begin
                    r_done  <= 1'b1;
                    r_state <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/frame_writer.md
# frame_writer

Streams camera pixels into the 36-bit frame memory in the exact layout `edge_detector` reads: one word per pixel at address `{row, col}` with 1024-word row stride, luminance in bits [29:20]. It sits between the pixel-capture front end and the frame-memory write port. It fills one frame per `start`/`done` handshake, so the frame is complete before `edge_detector` is launched.

## Interface
Parameters:
- `WIDTH`, 640, active pixels per row (≤1024)
- `HEIGHT`, 480, rows per frame (≤512)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state while 0
- `start`  in  1  one-cycle pulse; arms capture of one frame (ignored unless IDLE)
- `done`  out  1  one-cycle pulse after the last pixel's memory write is accepted
- `busy`  out  1  high in any state other than IDLE
- `sync_err`  out  1  sticky; set by an early SOF, cleared by `start`
- `pix_valid`  in  1  pixel present on `pix_data`
- `pix_sof`  in  1  qualifies the first pixel of a frame (meaningful only with `pix_valid`)
- `pix_data`  in  30  pixel, {luma[9:0], c1[9:0], c2[9:0]}
- `pix_ready`  out  1  block can accept a pixel this cycle
- `write_en`  out  1  memory write request
- `write_ready`  in  1  memory accepts the request this cycle
- `write_addr`  out  19  {row[8:0], col[9:0]}
- `write_data`  out  36  {6'b0, pix_data}

## Operation
- States: IDLE, WAIT_SOF, WRITE, DONE.
- IDLE: `pix_ready`=0, `write_en`=0.
  - `start` → WAIT_SOF.
  - `start` clears `sync_err`, row and col.
- WAIT_SOF:
  - `pix_ready`=1.
  - Pixels without SOF are consumed and discarded.
  - A pixel with `pix_valid & pix_sof` is stored as pixel (0,0) → WRITE.
- WRITE:
  - Accepted pixels enter the 2-entry buffer tagged with the current (row, col).
  - col increments; at WIDTH-1, col wraps to 0 and row increments.
  - After pixel (WIDTH-1, HEIGHT-1) is accepted, `pix_ready` drops and no further pixels are taken.
  - Once that pixel's write is accepted, go to DONE.
- DONE: `done`=1 for one cycle → IDLE.
- Early SOF: `pix_sof` on an accepted pixel in WRITE that is not (0,0).
  - Sets `sync_err`.
  - That pixel becomes (0,0); counters restart.
  - Writes already buffered still complete at their original addresses.
- Unused address space (col ≥ WIDTH) is never written.
- `pix_ready` = buffer not full in WAIT_SOF/WRITE (before the last pixel is taken). A pixel is accepted when `pix_valid & pix_ready`.

## Timing
- Reset values: `done`=0, `busy`=0, `sync_err`=0, `pix_ready`=0, `write_en`=0, `write_addr`=0, `write_data`=0; state IDLE.
- Latency: a pixel accepted in cycle N, with the buffer empty, drives `write_en` with its addr/data in cycle N+1.
- Write handshake: `write_en`, `write_addr` and `write_data` are registered. They are held stable until the cycle `write_ready`=1. The next buffered entry may appear in the following cycle, giving one write per cycle at full rate.
- `write_ready` may be low indefinitely. The buffer absorbs one extra pixel, then `pix_ready` goes low in the same cycle the buffer becomes full (registered full flag, no combinational path from `write_ready` to `pix_ready`).
- Simultaneous accept and drain on a full buffer: `pix_ready` is 0, so no accept occurs.
- Total frame time at full rate: WIDTH·HEIGHT + 2 cycles from the SOF pixel to `done`.
- `start` during a frame is ignored. `reset` asserted mid-frame aborts immediately with no further writes; the partial frame stays in memory.

## Structure
- Shared package `frame_pkg` holds:
  - `WORD_W`=36, `ADDR_W`=19, `COL_W`=10, `ROW_W`=9
  - luma field bounds [29:20]
  - a `pix_addr(row, col)` function shared with `edge_detector`
- Sub-module `pixel_skid_fifo`: 2-entry, 49-bit (addr + data) FIFO with registered full/empty. It is the only storage besides the FSM and counters.

## Test plan
- Reset, then `start` with WIDTH=6, HEIGHT=3 and constant `pix_valid`, SOF on the first pixel, `write_ready`=1 → 18 writes:
  - addresses 0–5, 1024–1029, 2048–2053
  - data {6'b0, pix_data}
  - `done` pulses exactly once, 20 cycles after the SOF pixel.
- Pixel at (0,3) with luma 500 → write at address 3 with `write_data[29:20]`=500. Rows 1 and 2 land at 1027 and 2051.
- Three non-SOF pixels before SOF → none written; the first write is the SOF pixel at address 0.
- `write_ready` held low for 10 cycles mid-row → `write_en`/addr/data held stable; `pix_ready` low after 2 pixels are buffered. No pixel is lost or duplicated; the address sequence is unchanged.
- SOF at (1,2) → `sync_err`=1 and the next writes restart at addresses 0,1,…. The next `start` clears `sync_err`.
- `reset` driven low during row 1 → all outputs return to their reset values immediately with no further `write_en`. A subsequent `start` behaves as the first scenario.
